// File: rtl/vrf_pkg.sv
// Shared FSM state type, default geometry and width helper for the VRF SRAM bank.
package vrf_pkg;

    localparam int unsigned VRF_DATA_W    = 32;
    localparam int unsigned VRF_DEPTH     = 32;
    localparam int unsigned VRF_MAX_BURST = 8;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_BURST = 2'd2
    } vrf_state_e;

    function automatic int unsigned len_width(input int unsigned max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/vrf_sram_array.sv
// Byte-enable SRAM with a registered read port and write-first forwarding; 1-cycle read latency.
// The read register only loads on rd_en, so a stalled consumer sees a stable snapshot.
module vrf_sram_array #(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned DEPTH  = 32,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BE_W-1:0]   wr_be,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
            // Same-cycle write to the read address: return the merged new bytes.
            if (wr_en && (wr_addr == rd_addr)) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (wr_be[i]) begin
                        rd_data_d[8*i +: 8] = wr_data[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/vrf_sram_bank.sv
// VRF bank: self-clearing SRAM with a write port and wrapping read bursts; first beat 1 cycle after accept, 1 beat/cycle.
// rd_ready low freezes the output beat and stops memory reads; new requests only accepted when idle.
module vrf_sram_bank
    import vrf_pkg::*;
#(
    parameter  int unsigned DATA_W    = VRF_DATA_W,
    parameter  int unsigned DEPTH     = VRF_DEPTH,
    parameter  int unsigned MAX_BURST = VRF_MAX_BURST,
    localparam int unsigned ADDR_W    = $clog2(DEPTH),
    localparam int unsigned BE_W      = DATA_W / 8,
    localparam int unsigned LEN_W     = len_width(MAX_BURST)
) (
    input  logic              clk,
    input  logic              nrst,
    output logic              init_done,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BE_W-1:0]   wr_be,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  logic [LEN_W-1:0]  rd_req_len,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last
);

    vrf_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              rd_valid_q, rd_valid_d;

    logic              arr_wr_en;
    logic [ADDR_W-1:0] arr_wr_addr;
    logic [BE_W-1:0]   arr_wr_be;
    logic [DATA_W-1:0] arr_wr_data;
    logic              arr_rd_en;
    logic [ADDR_W-1:0] arr_rd_addr;
    logic [DATA_W-1:0] arr_rd_data;
    logic              req_rdy;

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        rd_ptr_d    = rd_ptr_q;
        beat_d      = beat_q;
        len_d       = len_q;
        rd_valid_d  = rd_valid_q;
        arr_wr_en   = wr_en;
        arr_wr_addr = wr_addr;
        arr_wr_be   = wr_be;
        arr_wr_data = wr_data;
        arr_rd_en   = 1'b0;
        arr_rd_addr = rd_ptr_q;
        req_rdy     = 1'b0;

        unique case (state_q)
            ST_CLEAR: begin
                arr_wr_en   = 1'b1;
                arr_wr_addr = clr_addr_q;
                arr_wr_be   = '1;
                arr_wr_data = '0;
                clr_addr_d  = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                req_rdy = !rd_valid_q;
                if (rd_req_valid && req_rdy) begin
                    arr_rd_en   = 1'b1;
                    arr_rd_addr = rd_req_addr;
                    rd_ptr_d    = rd_req_addr + ADDR_W'(1);
                    len_d       = rd_req_len;
                    beat_d      = '0;
                    rd_valid_d  = 1'b1;
                    state_d     = ST_BURST;
                end
            end
            ST_BURST: begin
                if (rd_valid_q && rd_ready) begin
                    if (beat_q == len_q) begin
                        rd_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        // Fetch the next element as the current one is handed over.
                        arr_rd_en   = 1'b1;
                        arr_rd_addr = rd_ptr_q;
                        rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
                        beat_d      = beat_q + LEN_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            rd_ptr_q   <= '0;
            beat_q     <= '0;
            len_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            rd_ptr_q   <= rd_ptr_d;
            beat_q     <= beat_d;
            len_q      <= len_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    vrf_sram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .wr_en   (arr_wr_en),
        .wr_addr (arr_wr_addr),
        .wr_be   (arr_wr_be),
        .wr_data (arr_wr_data),
        .rd_en   (arr_rd_en),
        .rd_addr (arr_rd_addr),
        .rd_data (arr_rd_data)
    );

    assign init_done    = (state_q != ST_CLEAR);
    assign rd_req_ready = req_rdy;
    assign rd_valid     = rd_valid_q;
    assign rd_last      = rd_valid_q && (beat_q == len_q);
    assign rd_data      = rd_valid_q ? arr_rd_data : '0;

endmodule

// File: tb/tb_vrf_sram_bank.sv
// Directed vectors, corner-case sequences and a randomized run against a queue-based reference model.
module tb_vrf_sram_bank;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        nrst;
    logic        init_done;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [4:0]  rd_req_addr;
    logic [2:0]  rd_req_len;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        rd_last;

    always #5 clk = ~clk;

    vrf_sram_bank #(.DATA_W(32), .DEPTH(32), .MAX_BURST(8)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .init_done    (init_done),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_be        (wr_be),
        .wr_data      (wr_data),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_addr  (rd_req_addr),
        .rd_req_len   (rd_req_len),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_last      (rd_last)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] got_d[$];
    logic        got_l[$];
    logic [31:0] exp_d[$];
    int          burst_cyc;

    typedef struct {
        logic [4:0]  a;
        logic [3:0]  be;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[6];

    logic [31:0] mm[DEPTH];
    logic [4:0]  m_q[$];
    bit          m_vld;
    logic [31:0] m_data;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic idle_inputs();
        wr_en = 0; wr_addr = 0; wr_be = 0; wr_data = 0;
        rd_req_valid = 0; rd_req_addr = 0; rd_req_len = 0; rd_ready = 0;
    endtask

    task automatic wait_init(input string name);
        int cnt = 0;
        while (cnt < 100) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (init_done) break;
        end
        check(name, cnt, DEPTH);
    endtask

    task automatic wr(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1; wr_addr = a; wr_be = be; wr_data = d;
        @(negedge clk);
        wr_en = 0;
    endtask

    task automatic burst(input logic [4:0] a, input logic [2:0] len, input logic [31:0] rmask,
                         input int fw_c, input logic [4:0] fw_a, input logic [31:0] fw_d);
        int c = 0;
        bit done = 0;
        bit held_v = 0;
        logic [31:0] held_d;
        logic held_l;
        got_d.delete();
        got_l.delete();
        @(negedge clk);
        check("req_ready_when_idle", rd_req_ready, 1);
        rd_req_valid = 1; rd_req_addr = a; rd_req_len = len;
        @(posedge clk);
        @(negedge clk);
        rd_req_valid = 0;
        check("first_beat_latency rd_valid", rd_valid, 1);
        while (!done) begin
            if (c >= 200) begin
                checks++; errors++;
                $display("FAIL burst_timeout cycles %0d required < 200", c);
                break;
            end
            if (!rd_valid) begin
                check("burst_rd_valid_dropped_early", rd_valid, 1);
                break;
            end
            if (held_v) begin
                check("stall_data_stable", rd_data, held_d);
                check("stall_last_stable", rd_last, held_l);
            end
            wr_en = (c == fw_c); wr_addr = fw_a; wr_be = 4'hF; wr_data = fw_d;
            rd_ready = rmask[c % 32];
            held_v = !rd_ready; held_d = rd_data; held_l = rd_last;
            if (rd_ready) begin
                got_d.push_back(rd_data);
                got_l.push_back(rd_last);
                done = rd_last;
            end
            @(posedge clk);
            @(negedge clk);
            wr_en = 0; rd_ready = 0;
            c++;
        end
        burst_cyc = c;
        check("after_last rd_valid", rd_valid, 0);
        check("after_last rd_req_ready", rd_req_ready, 1);
    endtask

    task automatic compare_burst(input string name);
        check({name, " beats"}, got_d.size(), exp_d.size());
        for (int k = 0; k < exp_d.size() && k < got_d.size(); k++) begin
            check($sformatf("%s data[%0d]", name, k), got_d[k], exp_d[k]);
            check($sformatf("%s last[%0d]", name, k), got_l[k], k == exp_d.size() - 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, required finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mask;
        idle_inputs();
        nrst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset init_done", init_done, 0);
        check("reset rd_req_ready", rd_req_ready, 0);
        check("reset rd_valid", rd_valid, 0);
        check("reset rd_last", rd_last, 0);
        check("reset rd_data", rd_data, 0);
        nrst = 0;
        wait_init("init_done_latency");
        repeat (8) @(negedge clk);
        exp_d = {};
        for (int k = 0; k < 8; k++) exp_d.push_back(32'h0);
        burst(5'd0, 3'd7, 32'hFFFF_FFFF, -1, 5'd0, 32'h0);
        compare_burst("cleared_burst");
        check("full_throughput_cycles", burst_cyc, 8);

        vt[0] = '{5'd5,  4'hF, 32'hDEADBEEF, 32'hDEADBEEF};
        vt[1] = '{5'd5,  4'h1, 32'h000000AA, 32'hDEADBEAA};
        vt[2] = '{5'd5,  4'h0, 32'hFFFFFFFF, 32'hDEADBEAA};
        vt[3] = '{5'd5,  4'h6, 32'h11223344, 32'hDE2233AA};
        vt[4] = '{5'd31, 4'h8, 32'hAB000000, 32'hAB000000};
        vt[5] = '{5'd0,  4'hF, 32'h01020304, 32'h01020304};
        for (int i = 0; i < 6; i++) begin
            wr(vt[i].a, vt[i].be, vt[i].d);
            exp_d = {vt[i].exp};
            burst(vt[i].a, 3'd0, 32'hFFFF_FFFF, -1, 5'd0, 32'h0);
            compare_burst($sformatf("vec%0d", i));
        end

        for (int k = 0; k < DEPTH; k++) wr(5'(k), 4'hF, 32'(k));
        exp_d = {32'd30, 32'd31, 32'd0, 32'd1};
        burst(5'd30, 3'd3, 32'hFFFF_FFFF, -1, 5'd0, 32'h0);
        compare_burst("wrap_burst");
        check("wrap_burst_cycles", burst_cyc, 4);

        mask = 0;
        for (int c = 0; c < 32; c++) mask[c] = (c % 3 == 0);
        exp_d = {};
        for (int k = 4; k < 12; k++) exp_d.push_back(32'(k));
        burst(5'd4, 3'd7, mask, 1, 5'd5, 32'hCAFEF00D);
        compare_burst("stall_burst");
        check("stall_burst_cycles", burst_cyc, 22);
        exp_d = {32'hCAFEF00D};
        burst(5'd5, 3'd0, 32'hFFFF_FFFF, -1, 5'd0, 32'h0);
        compare_burst("write_behind_snapshot");

        exp_d = {32'd8, 32'd9, 32'h12345678, 32'd11};
        burst(5'd8, 3'd3, 32'hFFFF_FFFF, 1, 5'd10, 32'h12345678);
        compare_burst("forward_burst");

        @(negedge clk);
        rd_req_valid = 1; rd_req_addr = 5'd16; rd_req_len = 3'd7; rd_ready = 1;
        @(posedge clk); @(negedge clk);
        rd_req_valid = 0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check("midburst third_beat data", rd_data, 32'd18);
        nrst = 1;
        @(posedge clk); @(negedge clk);
        nrst = 0; rd_ready = 0;
        check("midburst_reset rd_valid", rd_valid, 0);
        check("midburst_reset init_done", init_done, 0);
        check("midburst_reset rd_req_ready", rd_req_ready, 0);
        wait_init("reclear_latency");
        exp_d = {};
        for (int k = 0; k < 8; k++) exp_d.push_back(32'h0);
        burst(5'd28, 3'd7, 32'hFFFF_FFFF, -1, 5'd0, 32'h0);
        compare_burst("reclear_burst");

        @(negedge clk);
        nrst = 1;
        @(posedge clk); @(negedge clk);
        nrst = 0;
        wait_init("random_phase_init");
        for (int k = 0; k < DEPTH; k++) mm[k] = 32'h0;
        m_q.delete();
        m_vld = 0;
        m_data = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check("rand rd_valid", rd_valid, m_vld);
            check("rand rd_req_ready", rd_req_ready, !m_vld);
            if (m_vld) begin
                check("rand rd_data", rd_data, m_data);
                check("rand rd_last", rd_last, m_q.size() == 0);
            end
            wr_en = 1'($urandom); wr_addr = 5'($urandom); wr_be = 4'($urandom); wr_data = $urandom;
            rd_req_valid = ($urandom_range(0, 3) == 0);
            rd_req_addr = 5'($urandom); rd_req_len = 3'($urandom);
            rd_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            if (wr_en) mm[wr_addr] = merge(mm[wr_addr], wr_data, wr_be);
            if (m_vld && rd_ready) begin
                if (m_q.size() == 0) m_vld = 0;
                else m_data = mm[m_q.pop_front()];
            end else if (!m_vld && rd_req_valid) begin
                m_vld = 1;
                m_data = mm[rd_req_addr];
                m_q.delete();
                for (int k = 1; k <= int'(rd_req_len); k++) m_q.push_back(5'(rd_req_addr + k));
            end
            @(negedge clk);
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
